ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv_pkg.sv | 52 +++++
 rtl/ex_muldiv_div_radix2.sv | 80 ++++++++
 rtl/ex_muldiv.sv | 205 ++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// Holds bus widths, reset/stall encodings, M-extension opcodes and an opcode decoder.
// No logic of its own; imported by ex_muldiv and div_radix2.
package ex_muldiv_pkg;

  localparam logic RST_ENABLE = 1'b0;
  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;

  localparam int ALU_OP_W   = 8;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

  localparam logic [ALU_OP_W-1:0] EXE_MUL_OP    = 8'hA8;
  localparam logic [ALU_OP_W-1:0] EXE_MULH_OP   = 8'hA9;
  localparam logic [ALU_OP_W-1:0] EXE_MULHSU_OP = 8'hAA;
  localparam logic [ALU_OP_W-1:0] EXE_MULHU_OP  = 8'hAB;
  localparam logic [ALU_OP_W-1:0] EXE_DIV_OP    = 8'hAC;
  localparam logic [ALU_OP_W-1:0] EXE_DIVU_OP   = 8'hAD;
  localparam logic [ALU_OP_W-1:0] EXE_REM_OP    = 8'hAE;
  localparam logic [ALU_OP_W-1:0] EXE_REMU_OP   = 8'hAF;

  // Per-op control bits derived from the opcode.
  typedef struct packed {
    logic is_mul;
    logic is_div;
    logic is_signed_div;
    logic want_hi;
    logic want_rem;
    logic a_signed;
    logic b_signed;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [ALU_OP_W-1:0] op);
    op_info_t d;
    d = '0;
    case (op)
      EXE_MUL_OP:    d.is_mul = 1'b1;
      EXE_MULH_OP:   begin d.is_mul = 1'b1; d.want_hi = 1'b1; d.a_signed = 1'b1; d.b_signed = 1'b1; end
      EXE_MULHSU_OP: begin d.is_mul = 1'b1; d.want_hi = 1'b1; d.a_signed = 1'b1; end
      EXE_MULHU_OP:  begin d.is_mul = 1'b1; d.want_hi = 1'b1; end
      EXE_DIV_OP:    begin d.is_div = 1'b1; d.is_signed_div = 1'b1; end
      EXE_DIVU_OP:   d.is_div = 1'b1;
      EXE_REM_OP:    begin d.is_div = 1'b1; d.is_signed_div = 1'b1; d.want_rem = 1'b1; end
      EXE_REMU_OP:   begin d.is_div = 1'b1; d.want_rem = 1'b1; end
      default:       d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ex_muldiv_div_radix2.sv
// Unsigned restoring radix-2 divider core, one quotient bit per cycle.
// Latency: ITERS cycles after start; done is asserted combinationally during the last step.
// No backpressure: flush or reset abandons the division immediately.
module div_radix2
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dsr_q;
  logic [CW-1:0]   cnt;
  logic            busy_q;

  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] rem_n;
  logic [XLEN-1:0] quo_n;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dsr_q};
    if (!diff[XLEN]) begin
      rem_n = diff[XLEN-1:0];
      quo_n = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_n = shifted[XLEN-1:0];
      quo_n = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt == LAST);
  assign quot = quo_n;
  assign rem  = rem_n;

  // Load on start, then step once per cycle until the last iteration.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || flush) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dsr_q  <= divisor;
      cnt    <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      if (cnt == LAST) begin
        cnt    <= '0;
        busy_q <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage RV32M multiply/divide unit with latched operands and a stall request to ctrl.
// Latency: MUL-class 2 cycles, DIV-class 1+DIV_ITERS cycles, div-by-zero/overflow 1 cycle.
// Holds stallreq_o while busy; annul_i or reset abandons the op with no done_o.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_ITERS = 32  // must equal XLEN: one quotient bit per iteration
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ALU_OP_W-1:0]   aluop_i,
  input  logic [XLEN-1:0]       reg1_i,
  input  logic [XLEN-1:0]       reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic                  annul_i,
  output logic [XLEN-1:0]       wdata_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic                  done_o,
  output logic                  stallreq_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t                  state;
  op_info_t                cur;

  logic [XLEN-1:0]         a_q;
  logic [XLEN-1:0]         b_q;
  logic                    want_hi_q;
  logic                    want_rem_q;
  logic                    a_sgn_q;
  logic                    b_sgn_q;
  logic                    neg_q;
  logic                    neg_r;
  logic                    wreg_l;
  logic [REG_ADDR_W-1:0]   wd_q;
  logic                    done_q;
  logic                    wreg_q;
  logic [XLEN-1:0]         wdata_q;

  logic                    b_zero;
  logic                    ovf;
  logic                    div_start;
  logic [XLEN-1:0]         dvd_abs;
  logic [XLEN-1:0]         dsr_abs;
  logic [XLEN-1:0]         spec_res;

  logic                    div_busy;
  logic                    div_done;
  logic [XLEN-1:0]         core_quot;
  logic [XLEN-1:0]         core_rem;
  logic [XLEN-1:0]         div_res;

  logic [XLEN:0]           ma;
  logic [XLEN:0]           mb;
  logic [2*XLEN-1:0]       wa;
  logic [2*XLEN-1:0]       wb;
  logic [2*XLEN-1:0]       prod;
  logic [XLEN-1:0]         mul_res;

  assign cur = decode_op(aluop_i);

  // Classify the incoming op and prepare divider operands and the short-cut result.
  always_comb begin
    b_zero    = (reg2_i == '0);
    ovf       = cur.is_signed_div && (reg1_i == INT_MIN) && (&reg2_i);
    div_start = (rst != RST_ENABLE) && !annul_i && (state == S_IDLE) &&
                cur.is_div && !b_zero && !ovf;
    dvd_abs   = (cur.is_signed_div && reg1_i[XLEN-1]) ? -reg1_i : reg1_i;
    dsr_abs   = (cur.is_signed_div && reg2_i[XLEN-1]) ? -reg2_i : reg2_i;
    if (b_zero) spec_res = cur.want_rem ? reg1_i : '1;
    else        spec_res = cur.want_rem ? '0 : reg1_i;
  end

  // Full 2*XLEN product of the latched operands, each sign- or zero-extended per op.
  always_comb begin
    ma      = {a_sgn_q & a_q[XLEN-1], a_q};
    mb      = {b_sgn_q & b_q[XLEN-1], b_q};
    wa      = {{(XLEN-1){ma[XLEN]}}, ma};
    wb      = {{(XLEN-1){mb[XLEN]}}, mb};
    prod    = wa * wb;
    mul_res = want_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  // Signed fix-up on the divider's final step, applied as the result is registered.
  always_comb begin
    if (want_rem_q) div_res = neg_r ? -core_rem : core_rem;
    else            div_res = neg_q ? -core_quot : core_quot;
  end

  // Stall request: raised as soon as an M-op appears in IDLE, dropped by annul or reset.
  always_comb begin
    stallreq_o = NO_STOP;
    if (rst != RST_ENABLE && !annul_i) begin
      case (state)
        S_IDLE:  if (cur.is_mul || cur.is_div) stallreq_o = STOP;
        S_MUL:   stallreq_o = STOP;
        S_DIV:   stallreq_o = div_busy ? STOP : NO_STOP;
        default: stallreq_o = NO_STOP;
      endcase
    end
  end

  div_radix2 #(
    .XLEN  (XLEN),
    .ITERS (DIV_ITERS)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .flush    (annul_i),
    .start    (div_start),
    .dividend (dvd_abs),
    .divisor  (dsr_abs),
    .busy     (div_busy),
    .done     (div_done),
    .quot     (core_quot),
    .rem      (core_rem)
  );

  // Control FSM; done_o/wreg_o/wdata_o are registered on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state      <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      want_hi_q  <= 1'b0;
      want_rem_q <= 1'b0;
      a_sgn_q    <= 1'b0;
      b_sgn_q    <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      wreg_l     <= 1'b0;
      wd_q       <= NOP_REG_ADDR;
      done_q     <= 1'b0;
      wreg_q     <= 1'b0;
      wdata_q    <= '0;
    end else if (annul_i) begin
      state   <= S_IDLE;
      done_q  <= 1'b0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      done_q  <= 1'b0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
      case (state)
        S_IDLE: begin
          if (cur.is_mul || cur.is_div) begin
            a_q        <= reg1_i;
            b_q        <= reg2_i;
            want_hi_q  <= cur.want_hi;
            want_rem_q <= cur.want_rem;
            a_sgn_q    <= cur.a_signed;
            b_sgn_q    <= cur.b_signed;
            neg_q      <= cur.is_signed_div && (reg1_i[XLEN-1] ^ reg2_i[XLEN-1]);
            neg_r      <= cur.is_signed_div && reg1_i[XLEN-1];
            wreg_l     <= wreg_i;
            wd_q       <= wd_i;
            if (cur.is_mul) begin
              state <= S_MUL;
            end else if (b_zero || ovf) begin
              state   <= S_DONE;
              done_q  <= 1'b1;
              wreg_q  <= wreg_i;
              wdata_q <= spec_res;
            end else begin
              state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          state   <= S_DONE;
          done_q  <= 1'b1;
          wreg_q  <= wreg_l;
          wdata_q <= mul_res;
        end
        S_DIV: begin
          if (div_done) begin
            state   <= S_DONE;
            done_q  <= 1'b1;
            wreg_q  <= wreg_l;
            wdata_q <= div_res;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign done_o  = done_q;
  assign wreg_o  = wreg_q;
  assign wdata_o = wdata_q;
  assign wd_o    = wd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv with an arithmetic reference model.
// Drives one op at a time, holding it during the stall like a real ID/EX register.
// A single negedge compare process checks every output on every cycle.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [ALU_OP_W-1:0]   aluop_i;
  logic [31:0]           reg1_i;
  logic [31:0]           reg2_i;
  logic [REG_ADDR_W-1:0] wd_i;
  logic                  wreg_i;
  logic                  annul_i;
  logic [31:0]           wdata_o;
  logic [REG_ADDR_W-1:0] wd_o;
  logic                  wreg_o;
  logic                  done_o;
  logic                  stallreq_o;

  int vectors = 0;
  int fails   = 0;

  logic                  chk_en     = 1'b0;
  logic                  chk_wd     = 1'b0;
  logic                  exp_done   = 1'b0;
  logic                  exp_stall  = 1'b0;
  logic                  exp_wreg   = 1'b0;
  logic [31:0]           exp_wdata  = '0;
  logic [REG_ADDR_W-1:0] exp_wd     = '0;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32), .DIV_ITERS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop_i),
    .reg1_i     (reg1_i),
    .reg2_i     (reg2_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .annul_i    (annul_i),
    .wdata_o    (wdata_o),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .done_o     (done_o),
    .stallreq_o (stallreq_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference result from RV32M arithmetic rules.
  function automatic logic [31:0] model_res(input logic [7:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa  = $signed(a);
    longint          sb  = $signed(b);
    longint unsigned ua  = a;
    longint unsigned ub  = b;
    longint          ps;
    longint unsigned pu;
    int              ia  = $signed(a);
    int              ib  = $signed(b);
    logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      EXE_MUL_OP:    begin pu = ua * ub; return pu[31:0]; end
      EXE_MULH_OP:   begin ps = sa * sb; return ps[63:32]; end
      EXE_MULHSU_OP: begin ps = sa * longint'(ub); return ps[63:32]; end
      EXE_MULHU_OP:  begin pu = ua * ub; return pu[63:32]; end
      EXE_DIV_OP:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      EXE_DIVU_OP:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      EXE_REM_OP:    return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      EXE_REMU_OP:   return (b == 0) ? a : a % b;
      default:       return 32'h0;
    endcase
  endfunction

  // Reference cycles from first op cycle to done_o.
  function automatic int model_lat(input logic [7:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    logic sgn = (op == EXE_DIV_OP) || (op == EXE_REM_OP);
    if (op inside {EXE_MUL_OP, EXE_MULH_OP, EXE_MULHSU_OP, EXE_MULHU_OP}) return 2;
    if (b == 0) return 1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op; optionally annul or reset at a given cycle offset (-1 = never).
  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wd, input logic wreg,
                        input int annul_at, input int rst_at);
    logic [31:0] res = model_res(op, a, b);
    int          lat = model_lat(op, a, b);
    for (int c = 0; c <= lat; c++) begin
      aluop_i = op; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wreg;
      annul_i = (c == annul_at);
      rst     = (c == rst_at) ? 1'b0 : 1'b1;
      if (c == annul_at || c == rst_at) begin
        exp_stall = 1'b0; exp_done = 1'b0; exp_wreg = 1'b0; exp_wdata = '0;
        chk_wd    = 1'b0;
        step();
        annul_i = 1'b0;
        rst     = 1'b1;
        return;
      end
      exp_stall = (c < lat);
      exp_done  = (c == lat);
      exp_wreg  = (c == lat) && wreg;
      exp_wdata = (c == lat) ? res : '0;
      exp_wd    = wd;
      chk_wd    = (c >= 1);
      step();
    end
  endtask

  task automatic idle(input int n, input logic [7:0] op);
    for (int i = 0; i < n; i++) begin
      aluop_i = op; annul_i = 1'b0; rst = 1'b1;
      exp_stall = 1'b0; exp_done = 1'b0; exp_wreg = 1'b0; exp_wdata = '0;
      step();
    end
  endtask

  // Per-cycle comparison of every output against the model's expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      check("done_o",     {31'b0, done_o},     {31'b0, exp_done});
      check("stallreq_o", {31'b0, stallreq_o}, {31'b0, exp_stall});
      check("wreg_o",     {31'b0, wreg_o},     {31'b0, exp_wreg});
      check("wdata_o",    wdata_o,             exp_wdata);
      if (chk_wd) check("wd_o", {27'b0, wd_o}, {27'b0, exp_wd});
    end
  end

  initial begin
    // Hand-computed anchors for the model itself.
    check("pin_mul_7x6",      model_res(EXE_MUL_OP,   32'd7, 32'd6), 32'd42);
    check("pin_mulh_m1",      model_res(EXE_MULH_OP,  32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0);
    check("pin_mulhu_max",    model_res(EXE_MULHU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    check("pin_div_m7_2",     model_res(EXE_DIV_OP,   32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("pin_rem_m7_2",     model_res(EXE_REM_OP,   32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("pin_divu_5_0",     model_res(EXE_DIVU_OP,  32'd5, 32'd0), 32'hFFFF_FFFF);
    check("pin_rem_ovf",      model_res(EXE_REM_OP,   32'h8000_0000, 32'hFFFF_FFFF), 32'h0);
    check("pin_lat_mul",      32'(model_lat(EXE_MUL_OP, 32'd7, 32'd6)), 32'd2);
    check("pin_lat_div",      32'(model_lat(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2)), 32'd33);
    check("pin_lat_divu0",    32'(model_lat(EXE_DIVU_OP, 32'd5, 32'd0)), 32'd1);

    rst = 1'b0; aluop_i = '0; reg1_i = '0; reg2_i = '0; wd_i = '0; wreg_i = 1'b0; annul_i = 1'b0;
    step();
    step();
    // Still in reset: everything at reset values, including wd_o.
    exp_wd = NOP_REG_ADDR; chk_wd = 1'b1; chk_en = 1'b1;
    step();
    idle(2, 8'h00);

    run_op(EXE_MUL_OP,    32'd7,          32'd6,          5'd3,  1'b1, -1, -1);
    run_op(EXE_MULH_OP,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd4,  1'b1, -1, -1);
    run_op(EXE_MULHU_OP,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd5,  1'b1, -1, -1);
    run_op(EXE_MULHSU_OP, 32'hFFFF_FFFF,  32'd2,          5'd6,  1'b1, -1, -1);
    run_op(EXE_MUL_OP,    32'h1234_5678,  32'h9ABC_DEF0,  5'd7,  1'b0, -1, -1);
    idle(1, 8'h00);
    run_op(EXE_DIV_OP,    32'hFFFF_FFF9,  32'd2,          5'd8,  1'b1, -1, -1);
    run_op(EXE_REM_OP,    32'hFFFF_FFF9,  32'd2,          5'd9,  1'b1, -1, -1);
    run_op(EXE_DIVU_OP,   32'd5,          32'd0,          5'd10, 1'b1, -1, -1);
    run_op(EXE_REM_OP,    32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 1'b1, -1, -1);
    run_op(EXE_DIV_OP,    32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 1'b1, -1, -1);
    run_op(EXE_REMU_OP,   32'd5,          32'd0,          5'd13, 1'b1, -1, -1);
    run_op(EXE_DIVU_OP,   32'hFFFF_FFFF,  32'd3,          5'd14, 1'b1, -1, -1);
    run_op(EXE_REMU_OP,   32'd100,        32'd7,          5'd15, 1'b0, -1, -1);
    run_op(EXE_DIV_OP,    32'd7,          32'hFFFF_FFFE,  5'd16, 1'b1, -1, -1);
    run_op(EXE_REM_OP,    32'd7,          32'hFFFF_FFFE,  5'd17, 1'b1, -1, -1);
    run_op(EXE_REM_OP,    32'hFFFF_FFF9,  32'hFFFF_FFFE,  5'd18, 1'b1, -1, -1);
    run_op(EXE_DIVU_OP,   32'h8000_0000,  32'hFFFF_FFFF,  5'd19, 1'b1, -1, -1);

    // Non-M opcode must be ignored entirely.
    idle(3, 8'h21);

    // Annul a divide at cycle 10; the next op is accepted in cycle 11.
    run_op(EXE_DIV_OP,    32'd1000,       32'd7,          5'd20, 1'b1, 10, -1);
    run_op(EXE_DIVU_OP,   32'd1000,       32'd7,          5'd21, 1'b1, -1, -1);

    // Reset at cycle 5 of a divide; no done_o afterward and wd_o back to NOP.
    run_op(EXE_DIV_OP,    32'd50,         32'd3,          5'd22, 1'b1, -1, 5);
    exp_wd = NOP_REG_ADDR; chk_wd = 1'b1;
    idle(40, 8'h00);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
